layer_controller: RTL and testbench

Sequences one fully-connected layer of `neuron` instances: it accepts a stream of layer inputs over a valid/ready handshake and broadcasts each one to every neuron as a one-cycle `neuronValid` pulse. It then waits until every neuron has produced its activated output, and serialises those outputs onto a valid/ready output stream. The block sits between the input buffer (or the previous layer's controller) and the next layer. When weights are not pretrained, it also routes weight and bias configuration writes to the addressed neuron.

---
 rtl/nn_pkg.sv | 22 ++
 rtl/layer_result_buffer.sv | 50 +++++
 rtl/layer_controller.sv | 186 ++++++++++++++++++
 tb/tb_layer_controller.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nn_pkg.sv
// Shared types and constants for the fully-connected layer sequencing blocks.
// No logic, so no latency.
// No handshakes here, so no backpressure behaviour.
package nn_pkg;

    localparam int NN_CFG_WIDTH = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FEED  = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DRAIN = 2'd3
    } lc_state_t;

    typedef struct packed {
        logic                    isBias;
        logic [NN_CFG_WIDTH-1:0] layer;
        logic [NN_CFG_WIDTH-1:0] neuron;
        logic [NN_CFG_WIDTH-1:0] data;
    } nn_cfg_cmd_t;

endpackage

// File: rtl/layer_result_buffer.sv
// Per-neuron result capture registers with "captured" flags and a read port.
// Capture is registered (1 cycle); allCaptured looks ahead to this cycle's strobes.
// No backpressure: strobes are accepted whenever capture is enabled.
module layer_result_buffer
    import nn_pkg::*;
#(
    parameter int numNeurons = 16,
    parameter int dataWidth  = 8,
    parameter int IW         = $clog2(numNeurons)
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            i_capEn,
    input  logic                            i_clear,
    input  logic [numNeurons*dataWidth-1:0] i_neuronOut,
    input  logic [numNeurons-1:0]           i_neuronOutValid,
    input  logic [IW-1:0]                   i_rdIdx,
    output logic [dataWidth-1:0]            o_rdData,
    output logic                            o_allCaptured
);

    logic [dataWidth-1:0]  r_result [numNeurons];
    logic [numNeurons-1:0] r_flag;
    logic [numNeurons-1:0] w_strobe;

    assign w_strobe      = i_capEn ? i_neuronOutValid : '0;
    // Counting strobes arriving this cycle lets the FSM leave WAIT one cycle earlier.
    assign o_allCaptured = &(r_flag | w_strobe);
    assign o_rdData      = r_result[i_rdIdx];

    // Capture every strobing neuron's slice; a repeat strobe simply overwrites.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_flag <= '0;
            for (int k = 0; k < numNeurons; k++) begin
                r_result[k] <= '0;
            end
        end else if (i_clear) begin
            r_flag <= '0;
        end else begin
            for (int k = 0; k < numNeurons; k++) begin
                if (w_strobe[k]) begin
                    r_result[k] <= i_neuronOut[k*dataWidth +: dataWidth];
                    r_flag[k]   <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/layer_controller.sv
// Sequences one FC layer: broadcast inputs to neurons, gather results, serialise them out.
// Input to neuronIn is 1 cycle; last capture to first outValid is 1 cycle; cfg writes 1 cycle.
// inReady drops from the last input until the final output handshake; outData holds while outReady=0.
// Config write path exists unless PRETRAINED_EN is defined.
module layer_controller
    import nn_pkg::*;
#(
    parameter int layerNumber = 0,
    parameter int numNeurons  = 16,
    parameter int numInputs   = 16,
    parameter int dataWidth   = 8
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            inValid,
    input  logic [dataWidth-1:0]            inData,
    output logic                            inReady,
    output logic [dataWidth-1:0]            neuronIn,
    output logic                            neuronValid,
    input  logic [numNeurons*dataWidth-1:0] neuronOut,
    input  logic [numNeurons-1:0]           neuronOutValid,
    output logic                            outValid,
    output logic [dataWidth-1:0]            outData,
    output logic [$clog2(numNeurons)-1:0]   outIndex,
    output logic                            outLast,
    input  logic                            outReady,
    output logic                            busy
`ifndef PRETRAINED_EN
    ,
    input  logic                            cfgValid,
    input  logic                            cfgIsBias,
    input  logic [NN_CFG_WIDTH-1:0]         cfgLayer,
    input  logic [NN_CFG_WIDTH-1:0]         cfgNeuron,
    input  logic [NN_CFG_WIDTH-1:0]         cfgData,
    output logic [numNeurons-1:0]           weightWriteEn,
    output logic [numNeurons-1:0]           biasWriteEn,
    output logic [NN_CFG_WIDTH-1:0]         weightData,
    output logic [NN_CFG_WIDTH-1:0]         biasData
`endif
);

    localparam int             IW       = $clog2(numNeurons);
    localparam int             CW       = $clog2(numInputs + 1);
    localparam logic [CW-1:0]  LAST_IN  = CW'(numInputs - 1);
    localparam logic [IW-1:0]  LAST_OUT = IW'(numNeurons - 1);

    lc_state_t            r_state;
    logic [CW-1:0]        r_inCount;
    logic [IW-1:0]        r_outIdx;
    logic                 r_inReady;
    logic                 r_outValid;
    logic                 r_neuronValid;
    logic [dataWidth-1:0] r_neuronIn;

    logic                 w_inHs;
    logic                 w_outHs;
    logic                 w_lastOut;
    logic                 w_capEn;
    logic                 w_clear;
    logic                 w_allCaptured;
    logic [dataWidth-1:0] w_rdData;

    assign w_inHs    = inValid & r_inReady;
    assign w_outHs   = r_outValid & outReady;
    assign w_lastOut = (r_outIdx == LAST_OUT);
    assign w_capEn   = (r_state == ST_WAIT);
    assign w_clear   = w_outHs & w_lastOut;

    layer_result_buffer #(
        .numNeurons (numNeurons),
        .dataWidth  (dataWidth),
        .IW         (IW)
    ) u_results (
        .clk              (clk),
        .reset            (reset),
        .i_capEn          (w_capEn),
        .i_clear          (w_clear),
        .i_neuronOut      (neuronOut),
        .i_neuronOutValid (neuronOutValid),
        .i_rdIdx          (r_outIdx),
        .o_rdData         (w_rdData),
        .o_allCaptured    (w_allCaptured)
    );

    assign inReady     = r_inReady;
    assign neuronIn    = r_neuronIn;
    assign neuronValid = r_neuronValid;
    assign outValid    = r_outValid;
    // Result registers are read live; gating keeps outData at zero outside DRAIN.
    assign outData     = r_outValid ? w_rdData : '0;
    assign outIndex    = r_outIdx;
    assign outLast     = r_outValid & w_lastOut;
    assign busy        = (r_state != ST_IDLE);

    // Layer sequencer: feed inputs, wait for all neurons, drain results.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state       <= ST_IDLE;
            r_inCount     <= '0;
            r_outIdx      <= '0;
            r_inReady     <= 1'b1;
            r_outValid    <= 1'b0;
            r_neuronValid <= 1'b0;
            r_neuronIn    <= '0;
        end else begin
            r_neuronValid <= 1'b0;
            case (r_state)
                ST_IDLE, ST_FEED: begin
                    if (w_inHs) begin
                        r_neuronIn    <= inData;
                        r_neuronValid <= 1'b1;
                        r_inCount     <= r_inCount + 1'b1;
                        if (r_inCount == LAST_IN) begin
                            r_state   <= ST_WAIT;
                            r_inReady <= 1'b0;
                        end else begin
                            r_state   <= ST_FEED;
                        end
                    end
                end
                ST_WAIT: begin
                    if (w_allCaptured) begin
                        r_state    <= ST_DRAIN;
                        r_outIdx   <= '0;
                        r_outValid <= 1'b1;
                    end
                end
                ST_DRAIN: begin
                    if (w_outHs) begin
                        if (w_lastOut) begin
                            r_state    <= ST_IDLE;
                            r_outValid <= 1'b0;
                            r_inReady  <= 1'b1;
                            r_inCount  <= '0;
                            r_outIdx   <= '0;
                        end else begin
                            r_outIdx   <= r_outIdx + 1'b1;
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

`ifndef PRETRAINED_EN
    localparam logic [NN_CFG_WIDTH-1:0] LAYER_ID  = NN_CFG_WIDTH'(layerNumber);
    localparam logic [NN_CFG_WIDTH-1:0] NEURON_LM = NN_CFG_WIDTH'(numNeurons);

    nn_cfg_cmd_t           w_cfg;
    logic                  w_cfgHit;
    logic [numNeurons-1:0] w_cfgSel;

    assign w_cfg    = '{isBias: cfgIsBias, layer: cfgLayer, neuron: cfgNeuron, data: cfgData};
    assign w_cfgHit = cfgValid && (r_state == ST_IDLE) &&
                      (w_cfg.layer == LAYER_ID) && (w_cfg.neuron < NEURON_LM);
    assign w_cfgSel = numNeurons'(1) << w_cfg.neuron;

    // Register config writes into a one-cycle enable plus payload to the addressed neuron.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            weightWriteEn <= '0;
            biasWriteEn   <= '0;
            weightData    <= '0;
            biasData      <= '0;
        end else begin
            weightWriteEn <= '0;
            biasWriteEn   <= '0;
            weightData    <= '0;
            biasData      <= '0;
            if (w_cfgHit) begin
                if (w_cfg.isBias) begin
                    biasWriteEn <= w_cfgSel;
                    biasData    <= w_cfg.data;
                end else begin
                    weightWriteEn <= w_cfgSel;
                    weightData    <= w_cfg.data;
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_layer_controller.sv
// Bench for layer_controller with 16 neurons x 4 inputs, driven at negedge and checked at negedge.
// The model tracks the layer pass as phases (accepting / waiting / draining) and expected results.
module tb_layer_controller;

    localparam int NN = 16;
    localparam int NI = 4;
    localparam int DW = 8;

    logic               clk = 1'b0;
    logic               reset;
    logic               inValid;
    logic [DW-1:0]      inData;
    logic               inReady;
    logic [DW-1:0]      neuronIn;
    logic               neuronValid;
    logic [NN*DW-1:0]   neuronOut;
    logic [NN-1:0]      neuronOutValid;
    logic               outValid;
    logic [DW-1:0]      outData;
    logic [3:0]         outIndex;
    logic               outLast;
    logic               outReady;
    logic               busy;
    logic               cfgValid;
    logic               cfgIsBias;
    logic [31:0]        cfgLayer;
    logic [31:0]        cfgNeuron;
    logic [31:0]        cfgData;
`ifndef PRETRAINED_EN
    logic [NN-1:0]      weightWriteEn;
    logic [NN-1:0]      biasWriteEn;
    logic [31:0]        weightData;
    logic [31:0]        biasData;
`endif

    always #5 clk = ~clk;

    layer_controller #(
        .layerNumber (0),
        .numNeurons  (NN),
        .numInputs   (NI),
        .dataWidth   (DW)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .inValid        (inValid),
        .inData         (inData),
        .inReady        (inReady),
        .neuronIn       (neuronIn),
        .neuronValid    (neuronValid),
        .neuronOut      (neuronOut),
        .neuronOutValid (neuronOutValid),
        .outValid       (outValid),
        .outData        (outData),
        .outIndex       (outIndex),
        .outLast        (outLast),
        .outReady       (outReady),
        .busy           (busy)
`ifndef PRETRAINED_EN
        ,
        .cfgValid       (cfgValid),
        .cfgIsBias      (cfgIsBias),
        .cfgLayer       (cfgLayer),
        .cfgNeuron      (cfgNeuron),
        .cfgData        (cfgData),
        .weightWriteEn  (weightWriteEn),
        .biasWriteEn    (biasWriteEn),
        .weightData     (weightData),
        .biasData       (biasData)
`endif
    );

    // Reference model: phase 0 accepting inputs, 1 waiting on neurons, 2 draining results.
    int            m_phase;
    int            m_cnt;
    int            m_oidx;
    logic [DW-1:0] m_res  [NN];
    bit            m_flag [NN];
    logic          e_nv;
    logic [DW-1:0] e_ni;
    logic [NN-1:0] e_wen, e_ben;
    logic [31:0]   e_wd, e_bd;

    int n_total = 0;
    int n_pass  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic model_clear();
        m_phase = 0;
        m_cnt   = 0;
        m_oidx  = 0;
        for (int k = 0; k < NN; k++) m_flag[k] = 1'b0;
        e_nv  = 1'b0;
        e_ni  = '0;
        e_wen = '0;
        e_ben = '0;
        e_wd  = '0;
        e_bd  = '0;
    endtask

    task automatic check_state();
        chk("inReady",     32'(inReady),     32'(m_phase == 0));
        chk("busy",        32'(busy),        32'(!(m_phase == 0 && m_cnt == 0)));
        chk("outValid",    32'(outValid),    32'(m_phase == 2));
        chk("neuronValid", 32'(neuronValid), 32'(e_nv));
        if (e_nv) chk("neuronIn", 32'(neuronIn), 32'(e_ni));
        if (m_phase == 2) begin
            chk("outIndex", 32'(outIndex), 32'(m_oidx));
            chk("outData",  32'(outData),  32'(m_res[m_oidx]));
            chk("outLast",  32'(outLast),  32'(m_oidx == NN - 1));
        end else begin
            chk("outLast_idle", 32'(outLast), 32'd0);
        end
`ifndef PRETRAINED_EN
        chk("weightWriteEn", 32'(weightWriteEn), 32'(e_wen));
        chk("biasWriteEn",   32'(biasWriteEn),   32'(e_ben));
        chk("weightData",    weightData,         e_wd);
        chk("biasData",      biasData,           e_bd);
`endif
    endtask

    // One clock: check what the previous edge produced, drive, predict, advance.
    task automatic cyc(input logic iv, input logic [DW-1:0] id, input logic ordy,
                       input logic [NN-1:0] nov, input logic [NN*DW-1:0] nout,
                       input logic cv, input logic cb, input logic [31:0] cl,
                       input logic [31:0] cn, input logic [31:0] cd);
        int  p;
        bit  all;
        check_state();
        inValid = iv; inData = id; outReady = ordy;
        neuronOutValid = nov; neuronOut = nout;
        cfgValid = cv; cfgIsBias = cb; cfgLayer = cl; cfgNeuron = cn; cfgData = cd;

        e_nv = (m_phase == 0) && iv;
        e_ni = id;
        e_wen = '0; e_ben = '0; e_wd = '0; e_bd = '0;
        if (m_phase == 0 && m_cnt == 0 && cv && cl == 0 && cn < NN) begin
            if (cb) begin e_ben = NN'(1) << cn; e_bd = cd; end
            else    begin e_wen = NN'(1) << cn; e_wd = cd; end
        end

        p = m_phase;
        if (p == 0) begin
            if (iv) begin
                m_cnt++;
                if (m_cnt == NI) m_phase = 1;
            end
        end else if (p == 1) begin
            all = 1'b1;
            for (int k = 0; k < NN; k++) begin
                if (nov[k]) begin m_res[k] = nout[k*DW +: DW]; m_flag[k] = 1'b1; end
                if (!m_flag[k]) all = 1'b0;
            end
            if (all) begin m_phase = 2; m_oidx = 0; end
        end else begin
            if (ordy) begin
                if (m_oidx == NN - 1) begin
                    m_phase = 0; m_cnt = 0; m_oidx = 0;
                    for (int k = 0; k < NN; k++) m_flag[k] = 1'b0;
                end else begin
                    m_oidx++;
                end
            end
        end
        @(negedge clk);
    endtask

    function automatic logic [NN*DW-1:0] rnd_wide();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Same as cyc but with a random config write attempt.
    task automatic rcyc(input logic iv, input logic [DW-1:0] id, input logic ordy,
                        input logic [NN-1:0] nov, input logic [NN*DW-1:0] nout);
        cyc(iv, id, ordy, nov, nout, ($urandom % 4) == 0, 1'($urandom % 2),
            32'($urandom % 2), 32'($urandom % 20), $urandom);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        inValid = 0; inData = '0; outReady = 0; neuronOutValid = '0; neuronOut = '0;
        cfgValid = 0; cfgIsBias = 0; cfgLayer = '0; cfgNeuron = '0; cfgData = '0;
        @(negedge clk);
        chk("rst_inReady",     32'(inReady),     32'd1);
        chk("rst_neuronValid", 32'(neuronValid), 32'd0);
        chk("rst_neuronIn",    32'(neuronIn),    32'd0);
        chk("rst_outValid",    32'(outValid),    32'd0);
        chk("rst_outData",     32'(outData),     32'd0);
        chk("rst_outIndex",    32'(outIndex),    32'd0);
        chk("rst_outLast",     32'(outLast),     32'd0);
        chk("rst_busy",        32'(busy),        32'd0);
`ifndef PRETRAINED_EN
        chk("rst_wen", 32'(weightWriteEn), 32'd0);
        chk("rst_ben", 32'(biasWriteEn),   32'd0);
        chk("rst_wd",  weightData,         32'd0);
        chk("rst_bd",  biasData,           32'd0);
`endif
        model_clear();
        reset = 1'b1;
        @(negedge clk);
    endtask

    // feed: 0 back-to-back 1..N, 1 alternating gaps, 2 random
    // strobe: 0 neuron 3, then 0, then the rest with k+10; 1 random with repeats
    // drain: 0 always ready, 1 five-cycle stall at index 7, 2 random
    // abort: reset once 8 neurons have been captured
    task automatic run_pass(input int feed, input int strobe, input int drain, input bit abort);
        int               t;
        int               stall;
        int               captured;
        logic             v;
        logic [DW-1:0]    d;
        logic [NN*DW-1:0] seq;
        logic [NN-1:0]    nov;

        t = 0;
        while (m_phase == 0 && t < 200) begin
            v = (feed == 0) ? 1'b1 : (feed == 1) ? (t % 2 == 0) : (($urandom % 3) != 0);
            d = (feed == 0) ? DW'(m_cnt + 1) : DW'($urandom);
            if (feed == 0 && t == 1)
                cyc(v, d, 1'b1, NN'($urandom), rnd_wide(), 1'b1, 1'b0, 32'd0, 32'd5, 32'hBEEF);
            else
                rcyc(v, d, 1'($urandom), NN'($urandom), rnd_wide());
            t++;
        end

        for (int k = 0; k < NN; k++) seq[k*DW +: DW] = DW'(k + 10);
        t = 0;
        captured = 0;
        if (strobe == 0) begin
            rcyc(1'b1, 8'hAA, 1'b1, 16'h0008, seq);
            rcyc(1'b0, 8'h00, 1'b1, 16'h0001, seq);
            rcyc(1'b1, 8'h55, 1'b1, 16'hFFF6, seq);
        end else begin
            while (m_phase == 1 && t < 300) begin
                if (abort) begin
                    if (captured == 8) begin
                        do_reset();
                        return;
                    end
                    nov = NN'(1) << (captured * 2);
                    captured++;
                end else if (t >= 40) begin
                    nov = '1;
                end else begin
                    nov = '0;
                    for (int k = 0; k < NN; k++) nov[k] = (($urandom % 4) == 0);
                end
                rcyc(1'($urandom), DW'($urandom), 1'($urandom), nov, rnd_wide());
                t++;
            end
        end

        stall = 0;
        t = 0;
        while (m_phase == 2 && t < 300) begin
            if (drain == 0) v = 1'b1;
            else if (drain == 1) begin
                v = !(m_oidx == 7 && stall < 5);
                if (!v) stall++;
            end else v = 1'($urandom);
            rcyc(1'($urandom), DW'($urandom), v, NN'($urandom), rnd_wide());
            t++;
        end
    endtask

    initial begin
        do_reset();
        run_pass(0, 0, 0, 1'b0);
        // Config writes in IDLE: good bias, wrong layer, out-of-range neuron, good weight.
        cyc(1'b0, '0, 1'b0, '0, '0, 1'b1, 1'b1, 32'd0, 32'd5,  32'h1234);
        cyc(1'b0, '0, 1'b0, '0, '0, 1'b1, 1'b1, 32'd1, 32'd5,  32'h1234);
        cyc(1'b0, '0, 1'b0, '0, '0, 1'b1, 1'b0, 32'd0, 32'd16, 32'h5678);
        cyc(1'b0, '0, 1'b0, '0, '0, 1'b1, 1'b0, 32'd0, 32'd15, 32'h9ABC);
        cyc(1'b0, '0, 1'b0, '0, '0, 1'b0, 1'b0, 32'd0, 32'd0,  32'd0);
        run_pass(1, 1, 1, 1'b0);
        run_pass(2, 1, 2, 1'b0);
        run_pass(2, 1, 2, 1'b1);
        run_pass(0, 1, 1, 1'b0);
        run_pass(2, 1, 0, 1'b0);
        check_state();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
